mac_sequencer: RTL and testbench
================================

# mac_sequencer

Sequenced multiply-accumulate controller for the Level-1 pipeline. It accepts a stream of LEN sign-magnitude operand pairs over a valid/ready handshake and time-shares one `fixed_point_multiply` instance across them. It accumulates the products in a saturating sign-magnitude accumulator and presents one dot-product result on an output handshake. It is the block that turns the combinational multiplier into a pipelined, flow-controlled datapath stage.

## Interface
- `BITSIZE`, 16, word width; sign-magnitude, sign in MSB, `BITSIZE-5` fraction bits (Q4.11 at 16)
- `LEN_W`, 8, width of the pair-count field
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `start` input 1: begin a new accumulation; honoured only in IDLE
- `len` input LEN_W: number of pairs, sampled when `start` is honoured
- `busy` output 1: high in RUN, DRAIN and DONE
- `in_valid` input 1: operand pair valid
- `in_ready` output 1: block accepts a pair
- `in_a` input BITSIZE: operand A
- `in_b` input BITSIZE: operand B
- `out_valid` output 1: result valid
- `out_ready` input 1: consumer accepts the result
- `out_data` output BITSIZE: accumulated result
- `out_ovf` output 1: sticky saturation flag for this result

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `start` with `len`≠0. On that transition: clear the accumulator to +0, clear `ovf`, set `cnt`=0 and latch `len`.
- IDLE → DONE on `start` with `len`=0. The result is +0 with `ovf`=0.
- RUN: `in_ready`=1. A pair is accepted when `in_valid`&`in_ready`. Each accept increments `cnt`. The accept with `cnt`==len-1 moves the block to DRAIN. Gaps in `in_valid` are legal.
- DRAIN: `in_ready`=0. This state lasts exactly one cycle, during which the last product is added. The block then moves to DONE.
- DONE: `out_valid`=1 and `out_data`/`out_ovf` are held stable. On `out_ready` the block moves to IDLE.
- `start` outside IDLE is ignored.
- Multiply: `fixed_point_multiply`. The sign is the XOR of the operand signs. The magnitude is the product of the two (BITSIZE-1)-bit magnitudes, shifted right by BITSIZE-5 and truncated to BITSIZE-1 bits. High product bits are discarded and not flagged.
- Product register: `p_reg` plus `p_v`, loaded on every accept.
- Accumulate when `p_v` is set. Sign-magnitude add:
  - Same signs: add the magnitudes. A carry out of BITSIZE-1 bits saturates the magnitude to all ones, keeps the sign and sets `ovf`.
  - Different signs: subtract the smaller magnitude from the larger. The result takes the sign of the larger.
  - A zero-magnitude result is always forced to +0, so -0 never appears.
- Reset (asynchronous, any state): state=IDLE. `busy`, `in_ready`, `out_valid` and `out_ovf` = 0; `out_data`, the accumulator, `p_reg`, `p_v` and `cnt` = 0.

## Timing
- Throughput is one pair per cycle in RUN. `in_ready` has no combinational dependence on `in_valid`.
- Latency: the last pair is accepted in cycle t. `p_reg` is valid in t+1, the accumulator updates at the end of t+1, and `out_valid` rises in cycle t+2.
- With `len`=0, `out_valid` rises in the cycle after `start`.
- `out_valid`, `out_data` and `out_ovf` are registered.
- The earliest next `start` is honoured in the cycle after the `out_valid`&`out_ready` handshake.
- `len` and `start` are don't-care outside IDLE.

## Structure
- Shared package `fxp_pkg`:
  - `BITSIZE` default and derived `FRAC = BITSIZE-5`
  - sign-magnitude word typedef
  - state enum
  - `SM_MAX_MAG` constant
- Sub-module: one `fixed_point_multiply` instance, instantiated unmodified.
- The sign-magnitude saturating add is kept as a function in `fxp_pkg` (`sm_add_sat`), so it can be reused by other Level-1 blocks.

## Test plan
- Basic dot product: `len`=3 with pairs (0x0800,0x0C00), (0x1000,0x0400), (0x8800,0x0200). Required: `out_data`=0x1200, `out_ovf`=0, and `out_valid` exactly 2 cycles after the last accept.
- Saturation: `len`=2 with two pairs of (0x1800,0x1800), so each product is 0x4800. Required: `out_data`=0x7FFF, `out_ovf`=1.
- Cancellation: `len`=2 with pairs (0x0800,0x0800) and (0x8800,0x0800). Required: `out_data`=0x0000, never 0x8000.
- Empty job: `start` with `len`=0. Required: next cycle `out_valid`=1, `out_data`=0x0000, and no `in_ready` pulse.
- Flow control:
  - Stimulus: `len`=4 with `in_valid` toggled 1,0,1,1,0,1. Required: 4 accepts.
  - Stimulus: hold `out_ready`=0 for 5 cycles, pulsing `start` meanwhile. Required: `out_data` stable, `in_ready`=0, `start` ignored; IDLE only after `out_ready`.
- Reset mid-RUN: assert `rst_n`=0 after 2 of 5 accepts. Required: all outputs 0 immediately (asynchronously). A following `len`=1 job with (0x0800,0x0800) then returns 0x0800 with no residue from the aborted job.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared sign-magnitude fixed-point types, FSM states and the saturating adder.
// Latency: none (types, constants and one combinational function).
// Backpressure: n/a.
package fxp_pkg;

    localparam int BITSIZE = 16;
    localparam int FRAC    = BITSIZE - 5;

    typedef logic [BITSIZE-1:0] sm_word_t;

    localparam logic [BITSIZE-2:0] SM_MAX_MAG = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic     ovf;
        sm_word_t word;
    } sm_add_t;

    // Sign-magnitude add. Equal signs add magnitudes and clamp to the largest
    // magnitude on carry-out (flagging ovf). Opposite signs subtract the smaller
    // magnitude from the larger and keep the larger's sign. Zero is always +0.
    function automatic sm_add_t sm_add_sat(input sm_word_t a, input sm_word_t b);
        sm_add_t               r;
        logic [BITSIZE-1:0]    sum;
        logic [BITSIZE-2:0]    ma;
        logic [BITSIZE-2:0]    mb;
        logic [BITSIZE-2:0]    mr;
        logic                  sr;
        ma    = a[BITSIZE-2:0];
        mb    = b[BITSIZE-2:0];
        sum   = '0;
        r.ovf = 1'b0;
        if (a[BITSIZE-1] == b[BITSIZE-1]) begin
            sum = {1'b0, ma} + {1'b0, mb};
            sr  = a[BITSIZE-1];
            if (sum[BITSIZE-1]) begin
                mr    = SM_MAX_MAG;
                r.ovf = 1'b1;
            end else begin
                mr = sum[BITSIZE-2:0];
            end
        end else if (ma >= mb) begin
            mr = ma - mb;
            sr = a[BITSIZE-1];
        end else begin
            mr = mb - ma;
            sr = b[BITSIZE-1];
        end
        if (mr == '0) begin
            sr = 1'b0;
        end
        r.word = {sr, mr};
        return r;
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Control, operand-stream and result handshakes of the MAC sequencer.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on operands, out_valid/out_ready on the result.
interface mac_sequencer_if #(
    parameter int BITSIZE = 16,
    parameter int LEN_W   = 8
);
    logic               start;
    logic [LEN_W-1:0]   len;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic [BITSIZE-1:0] in_a;
    logic [BITSIZE-1:0] in_b;
    logic               out_valid;
    logic               out_ready;
    logic [BITSIZE-1:0] out_data;
    logic               out_ovf;

    modport master (
        output start, len, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mac_sequencer_mult.sv
// Combinational sign-magnitude fixed-point multiply (FRAC = BITSIZE-5 fraction bits).
// Latency: 0 cycles.
// Backpressure: none; high product bits are silently dropped.
module fixed_point_multiply #(
    parameter int BITSIZE = 16
) (
    input  logic [BITSIZE-1:0] a,
    input  logic [BITSIZE-1:0] b,
    output logic [BITSIZE-1:0] y
);
    localparam int FRAC = BITSIZE - 5;
    localparam int MW   = BITSIZE - 1;

    logic [2*MW-1:0] full;
    logic            unused_bits;

    // Full-width magnitude product, then keep the window aligned to FRAC.
    assign full        = {{MW{1'b0}}, a[MW-1:0]} * {{MW{1'b0}}, b[MW-1:0]};
    assign y           = {a[MW] ^ b[MW], full[FRAC +: MW]};
    assign unused_bits = ^{full[2*MW-1:FRAC+MW], full[FRAC-1:0]};

endmodule

// File: rtl/mac_sequencer.sv
// Sequenced MAC: streams LEN operand pairs through one multiplier into a saturating accumulator.
// Latency: result valid 2 cycles after the last accepted pair (1 cycle after start when len=0).
// Backpressure: in_ready only in RUN (independent of in_valid); result held in DONE until out_ready.
module mac_sequencer #(
    parameter int BITSIZE = 16,
    parameter int LEN_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mac_sequencer_if.slave  bus
);
    import fxp_pkg::*;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [BITSIZE-1:0] acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [BITSIZE-1:0] p_reg_q, p_reg_d;
    logic               p_v_q, p_v_d;
    logic               out_valid_q, out_valid_d;

    logic               busy;
    logic               in_ready;
    logic               accept;
    logic               last_pair;
    logic               start_take;
    logic [BITSIZE-1:0] prod;
    sm_add_t            add_res;

    fixed_point_multiply #(
        .BITSIZE (BITSIZE)
    ) u_mult (
        .a (bus.in_a),
        .b (bus.in_b),
        .y (prod)
    );

    assign accept     = in_ready && bus.in_valid;
    assign last_pair  = (cnt_q == len_q - 1'b1);
    assign start_take = (state_q == ST_IDLE) && bus.start;
    assign add_res    = sm_add_sat(acc_q, p_reg_q);

    // State register; everything returns to IDLE on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic; an empty job skips straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && last_pair) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        out_valid_d = (state_d == ST_DONE);
    end

    // Output decode from the registered state.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        in_ready = (state_q == ST_RUN);
    end

    assign bus.busy      = busy;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
    assign bus.out_ovf   = ovf_q;

    // Datapath next values: job setup, product capture, accumulate of the prior product.
    always_comb begin
        cnt_d   = cnt_q;
        len_d   = len_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        p_reg_d = p_reg_q;
        p_v_d   = accept;
        if (start_take) begin
            cnt_d = '0;
            len_d = bus.len;
            acc_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (p_v_q) begin
                acc_d = add_res.word;
                ovf_d = ovf_q | add_res.ovf;
            end
            if (accept) begin
                cnt_d   = cnt_q + 1'b1;
                p_reg_d = prod;
            end
        end
    end

    // Datapath registers; the accumulator doubles as the held result in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            p_reg_q <= '0;
            p_v_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            p_reg_q <= p_reg_d;
            p_v_q   <= p_v_d;
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: directed cases plus random dot products.
// Reference model works on signed integers with clamping to +/-32767.
// Outputs sampled 1 time unit after each rising edge.
module tb_mac_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mac_sequencer_if #(.BITSIZE(16), .LEN_W(8)) bus ();

    mac_sequencer #(.BITSIZE(16), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] va[$];
    logic [15:0] vb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Dot product as real-valued fixed point: integer value in LSB units, clamped each step.
    task automatic model(input int n, output logic [15:0] d, output logic o);
        int acc, ma, mb, pm, p;
        acc = 0;
        o   = 1'b0;
        for (int i = 0; i < n; i++) begin
            ma = int'(va[i][14:0]);
            mb = int'(vb[i][14:0]);
            pm = ((ma * mb) >>> 11) & 32'h7FFF;
            p  = (va[i][15] ^ vb[i][15]) ? -pm : pm;
            acc = acc + p;
            if (acc > 32767) begin
                acc = 32767;
                o   = 1'b1;
            end else if (acc < -32767) begin
                acc = -32767;
                o   = 1'b1;
            end
        end
        d = (acc < 0) ? {1'b1, 15'(-acc)} : 16'(acc);
    endtask

    task automatic fill_random(input int n, input int maxmag);
        va.delete();
        vb.delete();
        for (int i = 0; i < n; i++) begin
            va.push_back({1'($urandom_range(0, 1)), 15'($urandom_range(0, maxmag))});
            vb.push_back({1'($urandom_range(0, 1)), 15'($urandom_range(0, maxmag))});
        end
    endtask

    // vmode: 0 = always valid, 1 = random gaps, 2 = repeating 1,0,1,1,0,1
    task automatic do_job(input string tag, input int n, input int vmode, input int hold,
                          output logic [15:0] got_d, output logic got_o);
        logic [15:0] exp_d;
        logic        exp_o;
        int          accepted, cycles;
        bit          hs;
        model(n, exp_d, exp_o);
        bus.start = 1'b1;
        bus.len   = 8'(n);
        step();
        bus.start = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 1);
        accepted = 0;
        cycles   = 0;
        while (accepted < n && cycles < 200) begin
            case (vmode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = 1'($urandom_range(0, 1));
                default: bus.in_valid = ((cycles % 6) == 1 || (cycles % 6) == 4) ? 1'b0 : 1'b1;
            endcase
            bus.in_a = va[accepted];
            bus.in_b = vb[accepted];
            hs = bus.in_valid && bus.in_ready;
            step();
            cycles++;
            if (hs) accepted++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_accepts"}, 32'(accepted), 32'(n));
        check({tag, "_drain_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_drain_rdy"}, 32'(bus.in_ready), 0);
        step();
        check({tag, "_valid"}, 32'(bus.out_valid), 1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
        check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(exp_o));
        got_d = bus.out_data;
        got_o = bus.out_ovf;
        for (int h = 0; h < hold; h++) begin
            bus.start = (h % 2) == 0;
            bus.len   = 8'd3;
            step();
            check({tag, "_hold_data"}, 32'(bus.out_data), 32'(exp_d));
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
            check({tag, "_hold_rdy"}, 32'(bus.in_ready), 0);
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_idle_busy"}, 32'(bus.busy), 0);
        check({tag, "_idle_valid"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        logic [15:0] d;
        logic        o;
        int          n;

        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_ovf", 32'(bus.out_ovf), 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic dot product: 1.5 + 1.0 - 0.25 = 2.25
        va = '{16'h0800, 16'h1000, 16'h8800};
        vb = '{16'h0C00, 16'h0400, 16'h0200};
        do_job("basic", 3, 0, 0, d, o);
        check("basic_const_data", 32'(d), 32'h1200);
        check("basic_const_ovf", 32'(o), 0);

        // Saturation: 9.0 + 9.0 overflows Q4.11
        va = '{16'h1800, 16'h1800};
        vb = '{16'h1800, 16'h1800};
        do_job("sat", 2, 0, 0, d, o);
        check("sat_const_data", 32'(d), 32'h7FFF);
        check("sat_const_ovf", 32'(o), 1);

        // Empty job right after a saturated one: must come back +0 with no ovf
        bus.start = 1'b1;
        bus.len   = 8'd0;
        check("empty_rdy_idle", 32'(bus.in_ready), 0);
        step();
        bus.start = 1'b0;
        check("empty_valid", 32'(bus.out_valid), 1);
        check("empty_data", 32'(bus.out_data), 0);
        check("empty_ovf", 32'(bus.out_ovf), 0);
        check("empty_rdy", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("empty_done", 32'(bus.out_valid), 0);

        // Cancellation must give +0, never -0
        va = '{16'h0800, 16'h8800};
        vb = '{16'h0800, 16'h0800};
        do_job("cancel", 2, 0, 0, d, o);
        check("cancel_const_data", 32'(d), 32'h0000);

        // Flow control: gapped valid pattern, then held result with start pulses
        fill_random(4, 16'h1FFF);
        do_job("gaps", 4, 2, 5, d, o);

        // Reset in the middle of a 5-pair job
        fill_random(5, 16'h3FFF);
        bus.start = 1'b1;
        bus.len   = 8'd5;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = va[0];
        bus.in_b     = vb[0];
        step();
        bus.in_a = va[1];
        bus.in_b = vb[1];
        step();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_out_data", 32'(bus.out_data), 0);
        check("mid_rst_out_ovf", 32'(bus.out_ovf), 0);
        step();
        rst_n = 1'b1;
        step();
        va = '{16'h0800};
        vb = '{16'h0800};
        do_job("post_rst", 1, 0, 0, d, o);
        check("post_rst_const", 32'(d), 32'h0800);

        // Random jobs with random gaps and mixed operand ranges
        for (int j = 0; j < 8; j++) begin
            n = $urandom_range(1, 10);
            fill_random(n, (j % 2 == 0) ? 16'h0FFF : 16'h7FFF);
            do_job("rand", n, 1, j % 3, d, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
